// File: rtl/mult_div_unit_pkg.sv
// Shared RV32M types: multiply/divide opcodes, the unit's FSM states and a
// conditional two's-complement helper used for sign fix-up.
package rv32i_types;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } mult_ops_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] x);
        return neg ? (32'd0 - x) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit_datapath.sv
// Unsigned iterative core: one shift-add multiply step or one restoring
// divide step per cycle. The *_next outputs expose the result of the step.
module mult_div_datapath #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              clear,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] product_next,
    output logic [XLEN-1:0]   quotient_next,
    output logic [XLEN-1:0]   remainder_next
);

    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   quo_reg;
    logic [XLEN-1:0]   rem_reg;
    logic [XLEN-1:0]   operand_reg;
    logic              is_div_reg;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     trial;

    // Multiplier sits in the low half of acc and shifts out as the product shifts in.
    always_comb begin
        mul_sum        = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, operand_reg} : '0);
        product_next   = {mul_sum, acc_reg[XLEN-1:1]};
        trial          = {rem_reg, quo_reg[XLEN-1]} - {1'b0, operand_reg};
        quotient_next  = {quo_reg[XLEN-2:0], ~trial[XLEN]};
        remainder_next = trial[XLEN] ? {rem_reg[XLEN-2:0], quo_reg[XLEN-1]} : trial[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg     <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            operand_reg <= '0;
            is_div_reg  <= 1'b0;
        end else if (clear) begin
            acc_reg     <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            operand_reg <= '0;
            is_div_reg  <= 1'b0;
        end else if (load) begin
            is_div_reg <= is_div;
            if (is_div) begin
                acc_reg     <= '0;
                quo_reg     <= a_mag;
                rem_reg     <= '0;
                operand_reg <= b_mag;
            end else begin
                acc_reg     <= {{XLEN{1'b0}}, b_mag};
                quo_reg     <= '0;
                rem_reg     <= '0;
                operand_reg <= a_mag;
            end
        end else if (step) begin
            if (is_div_reg) begin
                quo_reg <= quotient_next;
                rem_reg <= remainder_next;
            end else begin
                acc_reg <= product_next;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative RV32M unit: accepts one op from the mul reservation station,
// iterates 32 steps (or short-circuits divide corner cases) and pulses the CDB.
module mult_div_unit
    import rv32i_types::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [2:0]      issue_multop,
    input  logic [XLEN-1:0] issue_rs1_data,
    input  logic [XLEN-1:0] issue_rs2_data,
    input  logic [4:0]      issue_rd_addr,
    input  logic [4:0]      issue_rob_idx,
    output logic            cdb_mul_valid,
    output logic [XLEN-1:0] cdb_mul_data,
    output logic [4:0]      cdb_mul_rd_addr,
    output logic [4:0]      cdb_mul_rob_idx
);

    localparam int CNT_W = $clog2(ITER);

    md_state_t        state_reg;
    logic [CNT_W-1:0] counter_reg;
    mult_ops_t        op_reg;
    logic [4:0]       rd_reg;
    logic [4:0]       rob_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             valid_reg;
    logic [XLEN-1:0]  data_reg;
    logic [4:0]       cdb_rd_reg;
    logic [4:0]       cdb_rob_reg;

    mult_ops_t        op_in;
    logic             signed_a;
    logic             signed_b;
    logic             sign_a;
    logic             sign_b;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [XLEN-1:0]  special_result;
    logic             accept;
    logic             last_step;

    logic [2*XLEN-1:0] product_next;
    logic [2*XLEN-1:0] product_signed;
    logic [XLEN-1:0]   quotient_next;
    logic [XLEN-1:0]   remainder_next;
    logic [XLEN-1:0]   calc_result;

    assign op_in       = mult_ops_t'(issue_multop);
    assign issue_ready = (state_reg != MD_CALC);
    assign accept      = issue_valid & issue_ready & ~flush;
    assign last_step   = (state_reg == MD_CALC) && (counter_reg == CNT_W'(ITER - 1));

    // The datapath only sees magnitudes; signs are reapplied on the final step.
    always_comb begin
        signed_a = !(op_in inside {mulhu, divu, remu});
        signed_b = signed_a && (op_in != mulhsu);
        sign_a   = signed_a & issue_rs1_data[XLEN-1];
        sign_b   = signed_b & issue_rs2_data[XLEN-1];
        a_mag    = neg_if(sign_a, issue_rs1_data);
        b_mag    = neg_if(sign_b, issue_rs2_data);
        div_zero = op_in[2] && (issue_rs2_data == '0);
        div_ovf  = (op_in == div || op_in == rem)
                   && (issue_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                   && (issue_rs2_data == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_result = op_in[1] ? issue_rs1_data : '1;
        end else begin
            special_result = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    always_comb begin
        product_signed = neg_q_reg ? ('0 - product_next) : product_next;
        if (op_reg[2]) begin
            calc_result = op_reg[1] ? neg_if(neg_r_reg, remainder_next)
                                    : neg_if(neg_q_reg, quotient_next);
        end else if (op_reg == mul) begin
            calc_result = product_signed[XLEN-1:0];
        end else begin
            calc_result = product_signed[2*XLEN-1:XLEN];
        end
    end

    mult_div_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk            (clk),
        .rst            (rst),
        .load           (accept & ~special),
        .step           ((state_reg == MD_CALC) & ~flush),
        .clear          (flush),
        .is_div         (op_in[2]),
        .a_mag          (a_mag),
        .b_mag          (b_mag),
        .product_next   (product_next),
        .quotient_next  (quotient_next),
        .remainder_next (remainder_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= MD_IDLE;
            counter_reg <= '0;
            op_reg      <= mul;
            rd_reg      <= '0;
            rob_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            data_reg    <= '0;
            cdb_rd_reg  <= '0;
            cdb_rob_reg <= '0;
        end else begin
            valid_reg <= 1'b0;
            if (flush) begin
                state_reg   <= MD_IDLE;
                counter_reg <= '0;
            end else if (state_reg == MD_CALC) begin
                counter_reg <= counter_reg + CNT_W'(1);
                if (last_step) begin
                    state_reg   <= MD_DONE;
                    valid_reg   <= 1'b1;
                    data_reg    <= calc_result;
                    cdb_rd_reg  <= rd_reg;
                    cdb_rob_reg <= rob_reg;
                end
            end else if (accept) begin
                op_reg      <= op_in;
                rd_reg      <= issue_rd_addr;
                rob_reg     <= issue_rob_idx;
                neg_q_reg   <= sign_a ^ sign_b;
                neg_r_reg   <= sign_a;
                counter_reg <= '0;
                if (special) begin
                    state_reg   <= MD_DONE;
                    valid_reg   <= 1'b1;
                    data_reg    <= special_result;
                    cdb_rd_reg  <= issue_rd_addr;
                    cdb_rob_reg <= issue_rob_idx;
                end else begin
                    state_reg <= MD_CALC;
                end
            end else begin
                state_reg <= MD_IDLE;
            end
        end
    end

    // A flush in the DONE cycle must suppress the broadcast already registered.
    assign cdb_mul_valid   = valid_reg & ~flush;
    assign cdb_mul_data    = data_reg;
    assign cdb_mul_rd_addr = cdb_rd_reg;
    assign cdb_mul_rob_idx = cdb_rob_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed RV32M vectors, randomized ops
// against an arithmetic reference model, back-to-back issue, flush and reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [2:0]  issue_multop = 3'd0;
    logic [31:0] issue_rs1_data = 32'd0;
    logic [31:0] issue_rs2_data = 32'd0;
    logic [4:0]  issue_rd_addr = 5'd0;
    logic [4:0]  issue_rob_idx = 5'd0;
    logic        cdb_mul_valid;
    logic [31:0] cdb_mul_data;
    logic [4:0]  cdb_mul_rd_addr;
    logic [4:0]  cdb_mul_rob_idx;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_multop    (issue_multop),
        .issue_rs1_data  (issue_rs1_data),
        .issue_rs2_data  (issue_rs2_data),
        .issue_rd_addr   (issue_rd_addr),
        .issue_rob_idx   (issue_rob_idx),
        .cdb_mul_valid   (cdb_mul_valid),
        .cdb_mul_data    (cdb_mul_data),
        .cdb_mul_rd_addr (cdb_mul_rd_addr),
        .cdb_mul_rob_idx (cdb_mul_rob_idx)
    );

    // Reference: RV32M semantics written with wide integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        int              qa;
        int              qb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        qa = $signed(a);
        qb = $signed(b);
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(qa / qb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(qa % qb);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [4:0] rob);
        @(negedge clk);
        issue_valid    = 1'b1;
        issue_multop   = op;
        issue_rs1_data = a;
        issue_rs2_data = b;
        issue_rd_addr  = rd;
        issue_rob_idx  = rob;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    // lat = number of negedges after the accept edge until the pulse; 0 = no pulse within the window.
    task automatic wait_pulse(output int lat, output logic [31:0] d, output logic [4:0] r, output logic [4:0] o);
        lat = 0;
        d   = 32'd0;
        r   = 5'd0;
        o   = 5'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cdb_mul_valid === 1'b1) begin
                lat = k;
                d   = cdb_mul_data;
                r   = cdb_mul_rd_addr;
                o   = cdb_mul_rob_idx;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cdb_mul_valid, cdb_mul_data, cdb_mul_rd_addr, cdb_mul_rob_idx} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b data=%h rd=%0d rob=%0d, need all 0",
                     cdb_mul_valid, cdb_mul_data, cdb_mul_rd_addr, cdb_mul_rob_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b need 1", issue_ready);
        end
        $display("reset: released, issue_ready=%b", issue_ready);
    endtask

    task automatic test_directed;
        logic [2:0]  t_op  [13] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                                    3'd4, 3'd7, 3'd4, 3'd6, 3'd0};
        logic [31:0] t_a   [13] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                    32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0};
        logic [31:0] t_b   [13] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'd2, 32'd2, 32'd7, 32'd7,
                                    32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd12345};
        logic [31:0] t_exp [13] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                    32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                    32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
        int          t_lat [13] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33};
        int          lat;
        logic [31:0] d;
        logic [4:0]  r;
        logic [4:0]  o;
        logic [4:0]  rd;
        logic [4:0]  rob;
        for (int i = 0; i < 13; i++) begin
            rd  = (i == 0) ? 5'd5 : 5'(i + 1);
            rob = (i == 0) ? 5'd9 : 5'(20 + i);
            issue_op(t_op[i], t_a[i], t_b[i], rd, rob);
            if (t_lat[i] == 33) begin
                vectors++;
                if (issue_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL directed_busy[%0d]: issue_ready=%b need 0", i, issue_ready);
                end
            end
            wait_pulse(lat, d, r, o);
            vectors++;
            if (lat != t_lat[i] || d !== t_exp[i] || r !== rd || o !== rob) begin
                errors++;
                $display("FAIL directed[%0d]: got lat=%0d data=%h rd=%0d rob=%0d, need lat=%0d data=%h rd=%0d rob=%0d",
                         i, lat, d, r, o, t_lat[i], t_exp[i], rd, rob);
            end
            @(negedge clk);
            vectors++;
            if (cdb_mul_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_pulse_width[%0d]: valid=%b need 0", i, cdb_mul_valid);
            end
            $display("directed op=%0d a=%h b=%h -> data=%h lat=%0d", t_op[i], t_a[i], t_b[i], d, lat);
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [4:0]  rob;
        logic [31:0] exp_d;
        int          exp_lat;
        int          lat;
        logic [31:0] d;
        logic [4:0]  r;
        logic [4:0]  o;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            rd  = 5'($urandom);
            rob = 5'($urandom);
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'd0;
                default: ;
            endcase
            exp_d   = ref_model(op, a, b);
            exp_lat = ref_latency(op, a, b);
            issue_op(op, a, b, rd, rob);
            wait_pulse(lat, d, r, o);
            vectors++;
            if (lat != exp_lat || d !== exp_d || r !== rd || o !== rob) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d data=%h rd=%0d rob=%0d, need lat=%0d data=%h rd=%0d rob=%0d",
                         i, op, a, b, lat, d, r, o, exp_lat, exp_d, rd, rob);
            end
            $display("random op=%0d a=%h b=%h -> data=%h lat=%0d", op, a, b, d, lat);
        end
    endtask

    task automatic test_back_to_back;
        int          lat;
        logic [31:0] d;
        logic [4:0]  r;
        logic [4:0]  o;
        issue_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 5'd4);
        wait_pulse(lat, d, r, o);
        vectors++;
        if (lat != 33 || d !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d data=%h, need lat=33 data=ffffffeb", lat, d);
        end
        // Still inside the DONE cycle: offer the next op now.
        vectors++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_in_done: got %b need 1", issue_ready);
        end
        issue_valid    = 1'b1;
        issue_multop   = 3'd5;
        issue_rs1_data = 32'd100;
        issue_rs2_data = 32'd7;
        issue_rd_addr  = 5'd17;
        issue_rob_idx  = 5'd30;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        wait_pulse(lat, d, r, o);
        vectors++;
        if (lat != 33 || d !== 32'd14 || r !== 5'd17 || o !== 5'd30) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d data=%h rd=%0d rob=%0d, need lat=33 data=0000000e rd=17 rob=30",
                     lat, d, r, o);
        end
        $display("back_to_back: second pulse %0d cycles after first, data=%h", lat, d);
    endtask

    task automatic test_flush;
        int          lat;
        logic [31:0] d;
        logic [4:0]  r;
        logic [4:0]  o;
        issue_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8, 5'd8);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready: got %b need 1", issue_ready);
        end
        wait_pulse(lat, d, r, o);
        vectors++;
        if (lat != 0) begin
            errors++;
            $display("FAIL flush_calc_no_pulse: got pulse at %0d need none", lat);
        end
        // Flush landing exactly on the DONE cycle of a special-case divide.
        issue_op(3'd4, 32'd5, 32'd0, 5'd2, 5'd2);
        flush = 1'b1;
        #1;
        vectors++;
        if (cdb_mul_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_valid: got %b need 0", cdb_mul_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        // Request offered together with flush must be dropped.
        issue_valid    = 1'b1;
        flush          = 1'b1;
        issue_multop   = 3'd4;
        issue_rs2_data = 32'd0;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        flush       = 1'b0;
        wait_pulse(lat, d, r, o);
        vectors++;
        if (lat != 0) begin
            errors++;
            $display("FAIL flush_accept_blocked: got pulse at %0d need none", lat);
        end
        issue_op(3'd7, 32'd100, 32'd7, 5'd11, 5'd12);
        wait_pulse(lat, d, r, o);
        vectors++;
        if (lat != 33 || d !== 32'd2 || r !== 5'd11 || o !== 5'd12) begin
            errors++;
            $display("FAIL flush_recover: got lat=%0d data=%h rd=%0d rob=%0d, need lat=33 data=00000002 rd=11 rob=12",
                     lat, d, r, o);
        end
        $display("flush: recovery op data=%h lat=%0d", d, lat);
    endtask

    task automatic test_reset_mid_op;
        int          lat;
        logic [31:0] d;
        logic [4:0]  r;
        logic [4:0]  o;
        issue_op(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd21, 5'd22);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({cdb_mul_valid, cdb_mul_data, cdb_mul_rd_addr, cdb_mul_rob_idx} !== 43'd0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_op: got valid=%b data=%h rd=%0d rob=%0d ready=%b, need zeros and ready=1",
                     cdb_mul_valid, cdb_mul_data, cdb_mul_rd_addr, cdb_mul_rob_idx, issue_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_pulse(lat, d, r, o);
        vectors++;
        if (lat != 0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_stray: got pulse at %0d ready=%b, need none and ready=1", lat, issue_ready);
        end
        $display("reset_mid_op: aborted, ready=%b", issue_ready);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative RV32M execution unit behind the mul reservation station.
- Consumes the issued mul/div entry through a valid/ready handshake.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 iterations.
- Broadcasts the result on the CDB mul channel as a one-cycle pulse; it is the responder/transmitter for the issue side.

Parameters:
- XLEN, 32, operand/result width.
- ITER, 32, iterations per non-special op; must equal XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush (from cdb flush), synchronous
- issue_valid  in  1  issued mul entry valid (operands ready)
- issue_ready  out  1  unit can accept this cycle; drives mul_alu_available
- issue_multop  in  3  mult_ops_t, RV32M funct3 encoding
- issue_rs1_data  in  32  operand A
- issue_rs2_data  in  32  operand B
- issue_rd_addr  in  5  destination arch reg
- issue_rob_idx  in  5  destination ROB index
- cdb_mul_valid  out  1  result broadcast pulse
- cdb_mul_data  out  32  result
- cdb_mul_rd_addr  out  5  rd of result
- cdb_mul_rob_idx  out  5  ROB index of result

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, all cdb_* outputs 0; issue_ready=1 after reset deasserts.
- FSM states:
  - IDLE: issue_ready=1.
  - CALC: issue_ready=0.
  - DONE: issue_ready=1; cdb_mul_valid=1 for exactly this cycle.
- Accept = issue_valid & issue_ready & !flush. On accept, latch multop, rd_addr, rob_idx, operand magnitudes, and result sign.
  - Non-special op: go to CALC, counter=0.
  - Special divide case: go directly to DONE.
- CALC: one shift-add (mul) or restoring subtract-shift (div) step per cycle; counter++; after the 32nd step (counter==31) go to DONE.
- Latency: accept at edge E.
  - Normal op: cdb_mul_valid high in cycle E+33.
  - Special case: cdb_mul_valid high in cycle E+1.
- DONE with accept: return to CALC/DONE for the new op (back-to-back issue); without accept: IDLE.
- Outputs are registered. cdb_mul_data/rd/rob_idx are valid only with cdb_mul_valid and are held otherwise. No backpressure: the CDB mul channel is dedicated.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Datapath runs on 32-bit magnitudes (abs of signed operands; -2^31 magnitude = 0x80000000 unsigned).
- Multiply: 64-bit unsigned product; negated if result sign set.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return [63:32].
- Divide: quotient negated if sign(A)^sign(B) (signed ops); remainder takes sign of A.
- Special cases, decided at accept, no iteration:
  - Divide by zero (B==0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - Multiplies never take the special path, including zero operands.
- Flush:
  - Any state goes to IDLE next cycle; cdb_mul_valid forced 0 in the flush cycle, including a DONE cycle.
  - No accept during flush.
  - issue_ready may still read 1 during flush; the issue side gates on flush.
- Reset mid-operation: immediate abort, outputs 0, no broadcast.

Decomposition:
- Shared package rv32i_types holds:
  - mult_ops_t enum: mul=3'b000, mulh=001, mulhsu=010, mulhu=011, div=100, divu=101, rem=110, remu=111.
  - Mul-unit FSM state enum md_state_t {MD_IDLE, MD_CALC, MD_DONE}.
- Sub-module mult_div_datapath: per-step shift-add / restoring-divide registers (acc[63:0], quotient, remainder) with load/step/clear controls.
- Top level owns the FSM, counter, sign fix-up, special cases and CDB registers.

Test Plan:
- Reset: hold rst=0 mid-CALC, release -> cdb_mul_valid=0, issue_ready=1, no stray broadcast.
- MUL 7*-3, rd=5, rob=9 -> one pulse 33 cycles after accept: data 0xFFFFFFEB, rd 5, rob 9.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, pulse at E+1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM same -> 0.
- Back-to-back: second op accepted in the DONE cycle of the first -> two pulses 33 cycles apart.
- Flush at iteration 10 -> no pulse; issue_ready high the next cycle; next op completes correctly.
